// File: rtl/apb_initiator_pkg.sv
// Shared types and constants for the APB4 initiator.
package apb_initiator_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_e;

    localparam logic [2:0] APB_PPROT = 3'b000;

endpackage

// File: rtl/apb_initiator.sv
// APB4 initiator: single-outstanding command/response stream to APB transfers,
// with a bounded wait-state timeout on every access.
module apb_initiator
    import apb_initiator_pkg::*;
#(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned STRB_W  = DATA_W / 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    input  logic [STRB_W-1:0] cmd_wstrb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    output logic [STRB_W-1:0] pstrb,
    output logic [2:0]        pprot,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_e            state, state_d;
    logic [CNT_W-1:0]  cnt, cnt_d;
    logic              psel_d, penable_d, pwrite_d;
    logic [ADDR_W-1:0] paddr_d;
    logic [DATA_W-1:0] pwdata_d;
    logic [STRB_W-1:0] pstrb_d;
    logic              rsp_valid_d, rsp_err_d, rsp_timeout_d;
    logic [DATA_W-1:0] rsp_rdata_d;

    assign cmd_ready = (state == IDLE);
    assign pprot     = APB_PPROT;

    // State, wait counter and every registered output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            pwrite      <= 1'b0;
            paddr       <= '0;
            pwdata      <= '0;
            pstrb       <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            psel        <= psel_d;
            penable     <= penable_d;
            pwrite      <= pwrite_d;
            paddr       <= paddr_d;
            pwdata      <= pwdata_d;
            pstrb       <= pstrb_d;
            rsp_valid   <= rsp_valid_d;
            rsp_rdata   <= rsp_rdata_d;
            rsp_err     <= rsp_err_d;
            rsp_timeout <= rsp_timeout_d;
        end
    end

    // Next state and next output values; APB fields hold unless a command is taken.
    always_comb begin
        state_d       = state;
        cnt_d         = cnt;
        psel_d        = psel;
        penable_d     = penable;
        pwrite_d      = pwrite;
        paddr_d       = paddr;
        pwdata_d      = pwdata;
        pstrb_d       = pstrb;
        rsp_valid_d   = rsp_valid;
        rsp_rdata_d   = rsp_rdata;
        rsp_err_d     = rsp_err;
        rsp_timeout_d = rsp_timeout;

        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_d  = SETUP;
                    cnt_d    = '0;
                    psel_d   = 1'b1;
                    pwrite_d = cmd_write;
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_wdata;
                    pstrb_d  = cmd_write ? cmd_wstrb : '0;
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                // pready wins over a timeout landing in the same cycle.
                if (pready) begin
                    state_d       = RESP;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = pwrite ? '0 : prdata;
                    rsp_err_d     = pslverr;
                    rsp_timeout_d = 1'b0;
                end else if ((TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1))) begin
                    state_d       = RESP;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                end else if (cnt != '1) begin
                    cnt_d = cnt + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_apb_initiator.sv
// Randomized bench for apb_initiator: a behavioural APB responder plus a
// per-transaction model predicting latency and response fields.
module tb_apb_initiator;

    localparam int unsigned T = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [15:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_err, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic        psel, penable, pwrite;
    logic [15:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [31:0] prdata;
    logic        pready, pslverr;

    int n_tests = 0;
    int n_fail  = 0;

    int          rsp_wait   = 0;
    bit          rsp_slverr = 1'b0;
    logic [31:0] rsp_data   = '0;
    int          acc        = 0;

    apb_initiator #(.ADDR_W(16), .DATA_W(32), .STRB_W(4), .TIMEOUT(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    // Responder: completes on the (rsp_wait)-th ACCESS cycle, junk everywhere else.
    always @(negedge clk) begin
        if (psel && penable) begin
            pready  = (acc == rsp_wait);
            pslverr = (acc == rsp_wait) ? rsp_slverr : 1'($urandom);
            prdata  = (acc == rsp_wait) ? rsp_data : $urandom;
            acc++;
        end else begin
            acc     = 0;
            pready  = 1'($urandom);
            pslverr = 1'($urandom);
            prdata  = $urandom;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_txn(input bit wr, input logic [15:0] a, input logic [31:0] wd,
                          input logic [3:0] ws, input int w, input bit se,
                          input logic [31:0] rd, input int hold);
        bit          exp_to;
        int          exp_lat;
        logic [31:0] exp_rd;
        bit          exp_err;
        int          cyc;
        exp_to  = (w >= int'(T));
        exp_lat = exp_to ? 2 + int'(T) : 3 + w;
        exp_rd  = (wr || exp_to) ? 32'h0 : rd;
        exp_err = exp_to || se;
        rsp_wait = w; rsp_slverr = se; rsp_data = rd;

        chk("cmd_ready_idle", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = wd; cmd_wstrb = ws;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = 16'($urandom);
        cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
        cyc = 1;
        chk("setup_psel", psel, 1);
        chk("setup_penable", penable, 0);
        chk("setup_paddr", paddr, a);
        chk("setup_pwrite", pwrite, wr);
        chk("setup_pstrb", pstrb, wr ? ws : 4'h0);
        if (wr) chk("setup_pwdata", pwdata, wd);
        chk("busy_cmd_ready", cmd_ready, 0);
        while (!rsp_valid && cyc < 64) begin
            @(negedge clk);
            cyc++;
            if (!rsp_valid) begin
                chk("access_ctl", {psel, penable}, 2'b11);
                chk("access_paddr", paddr, a);
                chk("access_pstrb", pstrb, wr ? ws : 4'h0);
            end
        end
        chk("rsp_latency", cyc, exp_lat);
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rsp_err", rsp_err, exp_err);
        chk("rsp_timeout", rsp_timeout, exp_to);
        chk("rsp_apb_idle", {psel, penable}, 2'b00);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", rsp_valid, 1);
            chk("hold_fields", {rsp_rdata, rsp_err, rsp_timeout}, {exp_rd, exp_err, exp_to});
            chk("hold_cmd_ready", cmd_ready, 0);
            chk("hold_psel", psel, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("rsp_done", rsp_valid, 0);
        chk("post_cmd_ready", cmd_ready, 1);
        chk("post_paddr_hold", paddr, a);
    endtask

    initial begin
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
        pready = 1'b0; pslverr = 1'b0; prdata = '0;
        repeat (3) @(negedge clk);
        chk("reset_cmd_ready", cmd_ready, 1);
        chk("reset_outputs", {psel, penable, pwrite, paddr, pwdata, pstrb, pprot},
            {3'b000, 16'h0, 32'h0, 4'h0, 3'b000});
        chk("reset_rsp", {rsp_valid, rsp_rdata, rsp_err, rsp_timeout}, 35'h0);
        rst_n = 1'b1;
        @(negedge clk);

        do_txn(1'b1, 16'h0040, 32'hDEADBEEF, 4'hF, 0, 1'b0, 32'h0, 0);
        do_txn(1'b0, 16'h0044, 32'h12345678, 4'hF, 3, 1'b0, 32'h00020010, 0);
        do_txn(1'b1, 16'h0048, 32'hCAFEF00D, 4'h3, 1, 1'b1, 32'h0, 0);
        do_txn(1'b0, 16'h004C, 32'h0, 4'h0, 1000, 1'b0, 32'hFFFFFFFF, 0);
        do_txn(1'b0, 16'h0050, 32'h0, 4'h0, 0, 1'b0, 32'hA5A5A5A5, 0);
        do_txn(1'b0, 16'h0054, 32'h0, 4'hF, T - 1, 1'b0, 32'h13579BDF, 5);
        do_txn(1'b1, 16'h0058, 32'h0BADC0DE, 4'h9, T, 1'b0, 32'h0, 1);

        // Asynchronous reset while waiting in ACCESS.
        rsp_wait = 1000;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 16'h0060; cmd_wdata = 32'h1;
        cmd_wstrb = 4'hF;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_reset_access", {psel, penable}, 2'b11);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_apb", {psel, penable}, 2'b00);
        chk("midreset_cmd_ready", cmd_ready, 1);
        chk("midreset_rsp_valid", rsp_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("postreset_idle", {cmd_ready, psel, rsp_valid}, 3'b100);
        do_txn(1'b0, 16'h0064, 32'h0, 4'hF, 2, 1'b0, 32'h00C0FFEE, 0);

        for (int n = 0; n < 40; n++) begin
            do_txn(1'($urandom), 16'($urandom & 32'hFFFC), $urandom, 4'($urandom),
                   int'($urandom_range(0, T + 2)), 1'($urandom), $urandom,
                   int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
